// File: rtl/seg_source_arbiter.sv
// Shares one 4-digit 7-segment display between a base value and three prioritised requesters.
// A granted value is held for HOLD_TICKS*TICK_DIV cycles; a higher or equal priority request preempts it.
module seg_source_arbiter #(
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 500,
  parameter int W_DIV      = 17,
  parameter int W_HOLD     = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] BASE_VAL,
  input  logic [2:0] REQ,
  input  logic [7:0] VAL0,
  input  logic [7:0] VAL1,
  input  logic [7:0] VAL2,
  output logic [7:0] BIN_OUT,
  output logic [1:0] SRC,
  output logic       BUSY,
  output logic [2:0] ACK
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        state;
  logic [2:0]        pend;
  logic [7:0]        pval [3];
  logic [7:0]        val_in [3];
  logic [W_DIV-1:0]  div_cnt;
  logic [W_HOLD-1:0] hold_cnt;

  logic       any_pend;
  logic [1:0] low_idx;
  logic [1:0] cur_idx;
  logic       tick;
  logic       expire;
  logic       do_grant;
  logic       go_idle;
  logic [2:0] grant_vec;

  always_comb begin
    val_in[0] = VAL0;
    val_in[1] = VAL1;
    val_in[2] = VAL2;
  end

  always_comb begin
    any_pend = |pend;
    low_idx  = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
    // SRC is 1..3 while holding, so this is the index of the holding requester
    cur_idx  = SRC - 2'd1;
    tick     = (div_cnt == W_DIV'(TICK_DIV - 1));
    expire   = tick && (hold_cnt == W_HOLD'(HOLD_TICKS - 1));
    do_grant = 1'b0;
    go_idle  = 1'b0;
    if (state == ST_IDLE) begin
      do_grant = any_pend;
    end else begin
      do_grant = any_pend && ((low_idx <= cur_idx) || expire);
      go_idle  = expire && !any_pend;
    end
    grant_vec = do_grant ? (3'b001 << low_idx) : 3'b000;
  end

  assign BUSY = (state == ST_HOLD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      BIN_OUT  <= 8'd0;
      SRC      <= 2'd0;
      ACK      <= 3'b000;
      div_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      ACK <= grant_vec;
      if (do_grant) begin
        state    <= ST_HOLD;
        BIN_OUT  <= pval[low_idx];
        SRC      <= low_idx + 2'd1;
        div_cnt  <= '0;
        hold_cnt <= '0;
      end else if ((state == ST_IDLE) || go_idle) begin
        state    <= ST_IDLE;
        BIN_OUT  <= BASE_VAL;
        SRC      <= 2'd0;
        div_cnt  <= '0;
        hold_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        hold_cnt <= hold_cnt + W_HOLD'(1);
      end else begin
        div_cnt  <= div_cnt + W_DIV'(1);
      end
    end
  end

  // A strobe on the same edge as its own grant keeps the request pending with the new value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend <= 3'b000;
      for (int i = 0; i < 3; i++) pval[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (REQ[i]) begin
          pend[i] <= 1'b1;
          pval[i] <= val_in[i];
        end else if (grant_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/seg_source_arbiter.md
Name: seg_source_arbiter

Overview:
- Shares the single 4-digit 7-segment display (8-bit binary value in, BCD-decoded and multiplexed downstream) between three requesters, e.g. note number, velocity and parameter edits.
- When idle, the display shows a base value.
- A requester strobe takes the display for a fixed hold time, with priority preemption and queuing of pending updates.
- Output BIN_OUT drives the display driver's binary input directly.

Parameters:
- TICK_DIV, 100000: CLK cycles per hold tick (1 ms at 100 MHz); must be >= 1.
- HOLD_TICKS, 500: ticks a granted value stays on display; must be >= 1.
- W_DIV, 17: width of the tick divider; must hold TICK_DIV-1.
- W_HOLD, 10: width of the hold counter; must hold HOLD_TICKS-1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- BASE_VAL  in  8  value shown when no requester holds the display.
- REQ  in  3  update strobes, one per requester; REQ[0] has highest priority, REQ[2] lowest.
- VAL0  in  8  value for requester 0; sampled when REQ[0]=1.
- VAL1  in  8  value for requester 1; sampled when REQ[1]=1.
- VAL2  in  8  value for requester 2; sampled when REQ[2]=1.
- BIN_OUT  out  8  registered value to the display driver.
- SRC  out  2  current source: 0 = base, 1..3 = requester 0..2.
- BUSY  out  1  1 while in HOLD.
- ACK  out  3  one-cycle grant pulse, one-hot per requester.

Behaviour:
- **Reset** (RST_N=0, asynchronous): all state clears immediately.
  - BIN_OUT=0, SRC=0, BUSY=0, ACK=0.
  - Pending flags and pending values = 0; divider = 0; hold counter = 0; state = IDLE.
  - Reset mid-hold discards the held value and all pending requests.
- **Capture:**
  - REQ[i]=1 at an edge sets pend[i] and stores VALi into pval[i].
  - A repeated REQ[i] before grant overwrites pval[i]; only the last value is kept.
- **Arbitration** uses registered pend/pval only, so a REQ reaches the output no earlier than the second edge after it is sampled. Grant latency is 2 cycles.
- **Grant of i:**
  - BIN_OUT <= pval[i], SRC <= i+1, ACK[i] <= 1 for one cycle, BUSY <= 1.
  - Divider and hold counter restart at 0; state = HOLD.
  - pend[i] clears, except when REQ[i] is asserted on the same edge: set wins and pval[i] takes the new value.
- **IDLE:**
  - BIN_OUT <= BASE_VAL every cycle (1-cycle latency); SRC=0, BUSY=0.
  - If any pend is set, grant the lowest index set.
- **HOLD with current source c:**
  - Divider counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps and emits a tick; the hold counter increments on each tick.
  - A pending index i <= c (higher priority or same source) is granted immediately. This preempts the current value or, for the same source, refreshes the value and restarts the hold.
  - A pending index i > c waits.
- **Expiry:** on the tick where the hold counter equals HOLD_TICKS-1:
  - If any pend is set, grant the lowest index set (no IDLE cycle in between).
  - Otherwise go to IDLE; BIN_OUT <= BASE_VAL and SRC <= 0 on that same edge; BUSY <= 0.
- **Hold duration:** exactly HOLD_TICKS*TICK_DIV cycles from the grant edge to the expiry edge.
- **Precedence:** a grant and an expiry on the same edge resolve as a grant, and the grant restarts the hold.
- **Simultaneous REQ bits:** all are captured; the lowest index is granted first, and the others are served in index order as each hold expires or preempts.
- **Held value is frozen:** BIN_OUT does not change during HOLD except on a grant; BASE_VAL changes are ignored in HOLD.
- **Degenerate parameters:** TICK_DIV=1 gives a tick every cycle; HOLD_TICKS=1 expires on the first tick.

Test Plan:
(All scenarios use TICK_DIV=4, HOLD_TICKS=3, giving a 12-cycle hold.)
1. Reset check: hold RST_N=0 with REQ toggling, then release -> outputs 0 during reset; first edge after release gives BIN_OUT=BASE_VAL, SRC=0, BUSY=0.
2. Single request: BASE_VAL=7, pulse REQ[1] with VAL1=42 at edge t.
   - Edge t+2: BIN_OUT=42, SRC=2, ACK=3'b010 for one cycle, BUSY=1.
   - Edge t+14: BIN_OUT=7, SRC=0, BUSY=0.
3. Preemption: REQ[2] with VAL2=9 granted; 5 cycles later REQ[0] with VAL0=200.
   - Two edges later: BIN_OUT=200, SRC=1.
   - 12 cycles after that: BASE_VAL shown; the preempted requester 2 is not re-served.
4. Queuing: REQ[0] with VAL0=1 held; REQ[2] with VAL2=33 arrives mid-hold.
   - Stays BIN_OUT=1 until expiry.
   - Expiry edge: BIN_OUT=33, SRC=3, ACK=3'b100, no IDLE cycle.
5. Same-source refresh and simultaneous requests:
   - REQ[1] with VAL1=50 granted; REQ[1] again with VAL1=51 after 10 cycles -> BIN_OUT=51, hold restarts, total shown = 10+2+12 cycles.
   - REQ=3'b111 in one cycle -> sources served in order 1, 2, 3, 12 cycles each.
6. Reset mid-operation: assert RST_N=0 during HOLD with pend[2] set -> immediate zeros; after release only BASE_VAL is shown and no ACK occurs.
